// File: rtl/vend_ctrl.sv
// Vending controller: 50c-unit coin credit, dispense handshake, change return and refund on cancel/inactivity.
// Latency: credit and coin_rej update one edge after the input; disp_req/chg_req hold until the matching ack.
module vend_ctrl #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 6,
    parameter int TIMEOUT    = 255,
    localparam int CW        = $clog2(MAX_CREDIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          sel,
    input  logic          cancel,
    input  logic          disp_ack,
    input  logic          chg_ack,
    output logic          disp_req,
    output logic          chg_req,
    output logic          coin_rej,
    output logic [CW-1:0] credit,
    output logic          busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] idle_cnt;
    logic [CW:0]   coin_val;
    logic [CW:0]   sum;
    logic          accept;
    logic          activity;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = (CW+1)'(1);
            2'b10:   coin_val = (CW+1)'(2);
            default: coin_val = '0;
        endcase
    end

    // The extra bit keeps the overflow compare exact at MAX_CREDIT.
    assign sum      = {1'b0, credit} + coin_val;
    assign accept   = (coin == 2'b01 || coin == 2'b10) && (sum <= (CW+1)'(MAX_CREDIT));
    assign activity = accept || sel || cancel;

    assign busy     = (state != IDLE);
    assign disp_req = (state == VEND);
    assign chg_req  = (state == RETURN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit   <= '0;
            idle_cnt <= '0;
            coin_rej <= 1'b0;
        end else begin
            coin_rej <= (coin != 2'b00);
            idle_cnt <= '0;
            case (state)
                IDLE: begin
                    if (cancel && credit != '0) begin
                        state <= RETURN;
                    end else if (sel && credit >= CW'(PRICE)) begin
                        state <= VEND;
                    end else begin
                        if (accept) begin
                            credit   <= sum[CW-1:0];
                            coin_rej <= 1'b0;
                        end
                        // Quiet cycle with credit held: count toward the refund.
                        if (!activity && credit != '0) begin
                            if (idle_cnt == TW'(TIMEOUT - 1))
                                state <= RETURN;
                            else
                                idle_cnt <= idle_cnt + TW'(1);
                        end
                    end
                end
                VEND: begin
                    if (disp_ack) begin
                        credit <= credit - CW'(PRICE);
                        state  <= (credit == CW'(PRICE)) ? IDLE : RETURN;
                    end
                end
                RETURN: begin
                    if (credit == '0) begin
                        state <= IDLE;
                    end else if (chg_ack) begin
                        credit <= credit - CW'(1);
                        if (credit == CW'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed vector bench for vend_ctrl with PRICE=3, MAX_CREDIT=6, TIMEOUT=8.
module tb_vend_ctrl;

    localparam int PRICE = 3;
    localparam int MAXC  = 6;
    localparam int TMO   = 8;
    localparam int CW    = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    coin;
    logic          sel, cancel, disp_ack, chg_ack;
    logic          disp_req, chg_req, coin_rej, busy;
    logic [CW-1:0] credit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [1:0] coin;
        logic       sel, cancel, dack, cack;
        int         credit;
        logic       busy, disp, chg, rej;
    } vec_t;

    vec_t vecs[$];

    vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel),
        .disp_ack(disp_ack), .chg_ack(chg_ack), .disp_req(disp_req),
        .chg_req(chg_req), .coin_rej(coin_rej), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] c, input logic s, input logic cn,
                       input logic da, input logic ca, input int cr,
                       input logic b, input logic d, input logic ch, input logic rj);
        vec_t v;
        v.rst = r; v.coin = c; v.sel = s; v.cancel = cn; v.dack = da; v.cack = ca;
        v.credit = cr; v.busy = b; v.disp = d; v.chg = ch; v.rej = rj;
        vecs.push_back(v);
    endtask

    // Drive inputs after the falling edge, then sample 1ns past the rising edge.
    task automatic step(input logic r, input logic [1:0] c, input logic s, input logic cn,
                        input logic da, input logic ca);
        @(negedge clk);
        rst = r; coin = c; sel = s; cancel = cn; disp_ack = da; chg_ack = ca;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int cr, input logic b, input logic d,
                           input logic ch, input logic rj);
        chk({tag, " credit"},   int'(credit),   cr);
        chk({tag, " busy"},     int'(busy),     int'(b));
        chk({tag, " disp_req"}, int'(disp_req), int'(d));
        chk({tag, " chg_req"},  int'(chg_req),  int'(ch));
        chk({tag, " coin_rej"}, int'(coin_rej), int'(rj));
    endtask

    initial begin
        rst = 1'b1; coin = 2'b00; sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;

        //   rst coin  sel cn  da ca   credit busy disp chg rej
        add(1, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // exact price
        add(0, 2'b01, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 2'b01, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add(0, 2'b01, 0, 0, 0, 0,   3, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0, 0,   3, 1, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0,   3, 1, 1, 0, 0);
        add(0, 2'b00, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // change
        add(0, 2'b10, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0,   4, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0, 0,   4, 1, 1, 0, 0);
        add(0, 2'b00, 0, 0, 1, 0,   1, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0,   1, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        // overflow, back-to-back rejects, coin in VEND
        add(0, 2'b10, 0, 0, 0, 0,   2, 0, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0,   4, 0, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0,   6, 0, 0, 0, 0);
        add(0, 2'b01, 0, 0, 0, 0,   6, 0, 0, 0, 1);
        add(0, 2'b10, 0, 0, 0, 0,   6, 0, 0, 0, 1);
        add(0, 2'b00, 0, 0, 0, 0,   6, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 0, 0,   6, 1, 1, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0,   6, 1, 1, 0, 1);
        add(0, 2'b00, 0, 0, 1, 0,   3, 1, 0, 1, 0);
        add(0, 2'b01, 0, 0, 0, 1,   2, 1, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 1,   1, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        // invalid coin, ignored cancel/sel still evaluate the coin
        add(0, 2'b11, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        add(0, 2'b01, 0, 1, 0, 0,   1, 0, 0, 0, 0);
        add(0, 2'b01, 1, 0, 0, 0,   2, 0, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0,   4, 0, 0, 0, 0);
        // cancel beats sel; coin that cycle rejected
        add(0, 2'b01, 1, 1, 0, 0,   4, 1, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 1,   3, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1,   2, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1,   1, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        // stray acks in IDLE are ignored
        add(0, 2'b00, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        add(0, 2'b01, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 1, 1,   1, 0, 0, 0, 0);
        add(0, 2'b00, 0, 1, 0, 0,   1, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1,   0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].coin, vecs[i].sel, vecs[i].cancel, vecs[i].dack, vecs[i].cack);
            chk_all($sformatf("vec%0d", i), vecs[i].credit, vecs[i].busy, vecs[i].disp,
                    vecs[i].chg, vecs[i].rej);
        end

        // Timeout: RETURN on the 8th quiet edge after the coin.
        step(0, 2'b01, 0, 0, 0, 0);
        chk("to coin credit", int'(credit), 1);
        for (int k = 1; k <= TMO; k++) begin
            step(0, 2'b00, 0, 0, 0, 0);
            chk($sformatf("to quiet%0d busy", k), int'(busy), (k == TMO) ? 1 : 0);
        end
        chk("to chg_req", int'(chg_req), 1);
        step(0, 2'b00, 0, 0, 0, 1);
        chk_all("to ack", 0, 0, 0, 0, 0);

        // Control: a coin on quiet cycle 5 restarts the full count.
        step(0, 2'b01, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 2'b00, 0, 0, 0, 0);
        chk("toc pre busy", int'(busy), 0);
        step(0, 2'b01, 0, 0, 0, 0);
        chk("toc coin credit", int'(credit), 2);
        for (int k = 1; k <= TMO; k++) begin
            step(0, 2'b00, 0, 0, 0, 0);
            chk($sformatf("toc quiet%0d busy", k), int'(busy), (k == TMO) ? 1 : 0);
        end
        step(0, 2'b00, 0, 0, 0, 1);
        chk("toc ack1 credit", int'(credit), 1);
        step(0, 2'b00, 0, 0, 0, 1);
        chk_all("toc ack2", 0, 0, 0, 0, 0);

        // Reset in VEND, then a late disp_ack has no effect.
        step(0, 2'b10, 0, 0, 0, 0);
        step(0, 2'b01, 0, 0, 0, 0);
        step(0, 2'b00, 1, 0, 0, 0);
        chk_all("rst pre", 3, 1, 1, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0);
        chk_all("rst vend", 0, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 1, 0);
        chk_all("rst late ack", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Vending-sequence controller wrapping the coin-credit accumulator function.
- Tracks credit in 50-cent units and accepts coins only while idle.
- On a product select with sufficient credit, sequences the dispenser handshake, then returns change one 50c coin per handshake.
- Refunds the full credit on cancel or inactivity timeout. Sits between the coin validator, front-panel buttons, dispenser and change hopper.

Parameters:
- PRICE, 3, product price in 50c units; legal range 1..MAX_CREDIT.
- MAX_CREDIT, 6, maximum credit held in 50c units; a coin that would exceed it is rejected.
- TIMEOUT, 255, number of consecutive inactive IDLE cycles with nonzero credit before an automatic refund; must be >= 1.
- Derived localparam CW = $clog2(MAX_CREDIT+1), the credit width.

Ports:
- clk, in, 1, single clock; all state updates on posedge.
- rst, in, 1, synchronous active-high reset.
- coin, in, 2, coin code sampled each cycle: 00 none, 01 50c, 10 1 Euro, 11 invalid.
- sel, in, 1, product select; level-sampled each cycle.
- cancel, in, 1, refund request; level-sampled each cycle.
- disp_ack, in, 1, dispenser completed one product.
- chg_ack, in, 1, hopper ejected one 50c coin.
- disp_req, out, 1, dispense request; high throughout VEND.
- chg_req, out, 1, change request; high throughout RETURN.
- coin_rej, out, 1, one-cycle registered pulse: the previous cycle's coin was not credited.
- credit, out, CW, current credit (registered).
- busy, out, 1, state != IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, credit=0, idle_cnt=0, coin_rej=0. disp_req, chg_req and busy read 0 in the cycle after reset. Reset overrides everything, including mid-VEND and mid-RETURN; no pending handshake survives it.
- States: IDLE, VEND, RETURN. disp_req, chg_req and busy are Moore-decoded from state.
- Coin value: 01 = +1, 10 = +2.

IDLE evaluation, with priorities decided on the current (old) credit:
- 1) cancel && credit>0: next state RETURN; any coin that cycle is rejected.
- 2) sel && credit>=PRICE: next state VEND; any coin that cycle is rejected.
- 3) Otherwise a coin is accepted if valid and credit+value <= MAX_CREDIT, giving credit <= credit+value. Invalid coins and overflow coins are rejected.
- cancel with credit=0, or sel with credit<PRICE, is ignored (no state change); a coin in that cycle is still evaluated per 3).

Coin rejection:
- coin_rej=1 on the cycle after any non-00 coin that was not credited, including any coin presented in VEND or RETURN.
- Back-to-back rejected coins give back-to-back pulses.

Timeout:
- idle_cnt clears in any cycle that is not IDLE, has credit=0, or has an accepted coin, sel, or cancel (including ignored sel/cancel). Otherwise it increments.
- When idle_cnt == TIMEOUT-1 in an inactive IDLE cycle, next state is RETURN and idle_cnt clears.
- Net effect: RETURN is entered exactly TIMEOUT inactive cycles after the last activity.

VEND:
- disp_req=1 every cycle in VEND; sel, cancel and coins are ignored (coins are rejected).
- On disp_ack: credit <= credit-PRICE (never underflows). Next state is IDLE if the result is 0, else RETURN.

RETURN:
- chg_req=1 every cycle in RETURN.
- Each cycle with chg_ack: credit <= credit-1. On the ack that takes credit from 1 to 0, next state is IDLE in the same edge.
- Acks without a request (outside the owning state) are ignored.

Widths: all credit arithmetic is done in CW+1 bits for the overflow compare; the stored credit is always <= MAX_CREDIT.

Test Plan:
- Exact price: coins 01,01,01 on consecutive cycles -> credit 1,2,3. sel -> busy=1, disp_req=1. disp_ack -> credit=0, IDLE, chg_req never asserted.
- Change: coins 10,10 -> credit=4. sel -> VEND. disp_ack -> RETURN, credit=1. One chg_ack -> credit=0, IDLE. Exactly one chg_req handshake.
- Overflow and invalid: raise credit to 6. Coin 01 -> coin_rej pulse, credit stays 6. Coin 11 at credit 0 -> coin_rej pulse, credit 0. Coin 10 during VEND -> coin_rej pulse, credit unchanged.
- Cancel and priority: credit=4, cancel and sel together -> RETURN (not VEND). Four chg_ack -> credit=0, IDLE. disp_req never high.
- Timeout (TIMEOUT=8): coin 01, then 8 quiet cycles -> RETURN entered on the 8th edge, chg_req=1. Ack -> IDLE. A control run with a coin at quiet cycle 5 delays entry by a full 8 cycles from that coin.
- Reset mid-operation: rst during VEND with credit=3 -> next cycle state IDLE, credit 0, disp_req 0, busy 0. A late disp_ack arriving after that -> no effect.
